// File: rtl/ledg_pkg.sv
// Shared constants and sizing helpers for the green-LED PWM driver.
package ledg_pkg;

    localparam int LEDG_WIDTH = 8;

    // Width of a counter that covers 0..n-1. A counter never gets fewer than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ledg_tick_gen.sv
// Prescaler plus PWM step counter. The counter advances once every PRESCALE
// clocks and wraps once every PRESCALE * 2^PWM_BITS clocks.
module ledg_tick_gen
    import ledg_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset,
    output logic                tick,
    output logic                wrap,
    output logic [PWM_BITS-1:0] pwm_cnt
);

    localparam int PRE_W = cnt_width(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        tick      = (pre_cnt_q == PRE_LAST);
        wrap      = tick && (pwm_cnt_q == '1);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        if (reset) begin
            pre_cnt_d = '0;
            pwm_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        pre_cnt_q <= pre_cnt_d;
        pwm_cnt_q <= pwm_cnt_d;
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/ledg_pwm_driver.sv
// Drives the LEDG pins from the PIO pattern with period-aligned PWM dimming
// and optional per-LED blinking.
module ledg_pwm_driver
    import ledg_pkg::*;
#(
    parameter int WIDTH         = LEDG_WIDTH,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 50,
    parameter int BLINK_PERIODS = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    led_in,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                blink_en,
    input  logic [WIDTH-1:0]    blink_mask,
    output logic [WIDTH-1:0]    led_out,
    output logic                period_start,
    output logic                in_changed
);

    localparam int BLK_W = cnt_width(BLINK_PERIODS);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_PERIODS - 1);

    logic                tick, wrap;
    logic [PWM_BITS-1:0] pwm_cnt;

    ledg_tick_gen #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt)
    );

    logic                first_q, first_d;
    logic                step_start_q, step_start_d;
    logic [PWM_BITS-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0]    led_sh_q, led_sh_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [WIDTH-1:0]    led_in_q, led_in_d;
    logic [WIDTH-1:0]    led_out_q, led_out_d;
    logic                period_start_q, period_start_d;
    logic                in_changed_q, in_changed_d;
    logic                load, pwm_on;

    always_comb begin
        // The first post-reset cycle sits at count 0 with stale shadows, so it
        // loads them but is not announced as a period start.
        load           = wrap | first_q;
        pwm_on         = (duty_sh_q == '1) || (pwm_cnt < duty_sh_q);
        first_d        = reset;
        step_start_d   = reset | tick;
        duty_sh_d      = load ? duty   : duty_sh_q;
        led_sh_d       = load ? led_in : led_sh_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        led_in_d       = led_in;
        led_out_d      = led_sh_q & {WIDTH{pwm_on}}
                       & ~(blink_mask & {WIDTH{blink_en & blink_phase_q}});
        period_start_d = !first_q && step_start_q && (pwm_cnt == '0);
        in_changed_d   = !first_q && (led_in != led_in_q);

        if (!blink_en) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (wrap) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (reset) begin
            duty_sh_d      = '0;
            led_sh_d       = '0;
            blink_cnt_d    = '0;
            blink_phase_d  = 1'b0;
            led_in_d       = '0;
            led_out_d      = '0;
            period_start_d = 1'b0;
            in_changed_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        first_q        <= first_d;
        step_start_q   <= step_start_d;
        duty_sh_q      <= duty_sh_d;
        led_sh_q       <= led_sh_d;
        blink_cnt_q    <= blink_cnt_d;
        blink_phase_q  <= blink_phase_d;
        led_in_q       <= led_in_d;
        led_out_q      <= led_out_d;
        period_start_q <= period_start_d;
        in_changed_q   <= in_changed_d;
    end

    assign led_out      = led_out_q;
    assign period_start = period_start_q;
    assign in_changed   = in_changed_q;

endmodule

// File: doc/ledg_pwm_driver.md
Name: ledg_pwm_driver

Overview:
- Downstream consumer of the green-LED PIO output port.
- Takes the 8-bit LED pattern written by software and drives the physical LEDG pins.
- Applies a global PWM brightness and optional per-LED blinking.
- Sits between the PIO's out_port and the top-level LEDG pins, entirely in the system clock domain.

Parameters:
- WIDTH, 8, number of LEDs / width of led_in and led_out.
- PWM_BITS, 8, PWM counter and duty width.
- PRESCALE, 50, clk cycles per PWM step (>=1).
- BLINK_PERIODS, 256, full PWM periods per blink half-cycle (>=1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- led_in  input  WIDTH  LED pattern from PIO out_port.
- duty  input  PWM_BITS  brightness; 0 = off, all-ones = fully on.
- blink_en  input  1  global blink enable.
- blink_mask  input  WIDTH  per-LED blink select (1 = this LED blinks).
- led_out  output  WIDTH  registered drive to LEDG pins.
- period_start  output  1  one-cycle pulse on the first cycle of each PWM period.
- in_changed  output  1  one-cycle pulse when led_in differs from its value on the previous cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). No asynchronous logic.
- Reset:
  - All counters = 0; duty_sh = 0; led_sh = 0; blink_phase = 0; led_in_q = 0.
  - led_out = 0; period_start = 0; in_changed = 0.
  - Reset asserted mid-period aborts immediately; the first period after release starts from count 0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick = (pre_cnt == PRESCALE-1).
  - PRESCALE=1 gives tick every cycle.
- PWM counter:
  - pwm_cnt (PWM_BITS) increments on tick and wraps from 2^PWM_BITS-1 to 0.
  - wrap = tick && pwm_cnt == max. Period = PRESCALE * 2^PWM_BITS cycles.
- Shadowing:
  - On wrap (and on the first cycle after reset release): duty_sh <= duty and led_sh <= led_in.
  - duty and led_in changes therefore take effect only at a period boundary, so PWM is glitch-free.
- pwm_on:
  - duty_sh == all-ones -> always 1.
  - Otherwise pwm_on = (pwm_cnt < duty_sh), unsigned compare.
  - duty_sh == 0 -> always 0.
- Blink:
  - blink_cnt counts wraps, 0..BLINK_PERIODS-1.
  - On its terminal wrap, blink_phase toggles and blink_cnt returns to 0.
  - blink_en == 0 forces blink_cnt = 0 and blink_phase = 0 on the next cycle.
  - After blink_en rises, the first "off" phase begins BLINK_PERIODS periods later.
- Output (registered, 1-cycle latency from internal state):
  - led_out[i] <= led_sh[i] & pwm_on & ~(blink_en & blink_mask[i] & blink_phase).
- period_start:
  - Registered.
  - Asserted the cycle pwm_cnt == 0 and pre_cnt == 0.
  - This coincides with the first cycle led_out reflects the new shadows.
- in_changed:
  - led_in_q <= led_in every cycle; in_changed <= (led_in != led_in_q).
  - Not asserted on the first cycle after reset.
- Simultaneous events:
  - wrap and a blink-terminal wrap in the same cycle: both shadows load and phase toggles together.
  - blink_en falling on a blink-terminal cycle: force-to-0 wins.

Decomposition:
- Package ledg_pkg: LEDG_WIDTH=8 default constant, plus a function computing counter width from BLINK_PERIODS / PRESCALE (clog2).
- One natural sub-module, ledg_tick_gen, holding the prescaler and pwm_cnt. It outputs tick, wrap and pwm_cnt.
- Blink logic, shadows and output register stay in ledg_pwm_driver.

Test Plan (bench uses PWM_BITS=4, PRESCALE=2, BLINK_PERIODS=2; period = 32 cycles):
1. Reset, then led_in=8'hFF, duty=4'd4, blink_en=0 -> after first period_start, every led_out bit is high for exactly 8 cycles and low for 24, per 32-cycle period.
2. duty=0 and then duty=4'hF with led_in=8'hA5 -> led_out=0 constantly; then led_out=8'hA5 constantly, starting at the next period_start.
3. Change duty 4->12 mid-period -> the current period keeps 8 high cycles; the next period has 24.
4. blink_en=1, blink_mask=8'h0F, led_in=8'hFF, duty=4'hF:
   - led_out=8'hFF for 2 periods (64 cycles), then 8'hF0 for 64 cycles, then repeats.
   - Dropping blink_en restores 8'hFF within 2 cycles.
5. led_in steps 8'h00->8'h3C at cycle N -> in_changed high only at cycle N+1; led_out shows 8'h3C only from the next period_start.
6. Assert reset for 1 cycle mid-period while led_out=8'hFF:
   - led_out=0 and period_start=0 the following cycle.
   - First period_start follows exactly 32 cycles after the first post-reset period begins.
